// File: rtl/imem_ctrl_pkg.sv
// Shared types and constants for the instruction-memory load/fetch controller.
// The range helper is used by the fetch issue logic before every read.
package imem_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_LOAD  = 2'd0,
    ST_TURN  = 2'd1,
    ST_FETCH = 2'd2,
    ST_ERROR = 2'd3
  } state_t;

  localparam logic        MEM_RW_WRITE            = 1'b0;
  localparam logic        MEM_RW_READ             = 1'b1;
  localparam logic [31:0] DEFAULT_PC_BASE_ADDR    = 32'h8002_0000;
  localparam int          DEFAULT_MEM_DEPTH_WORDS = 1024;
  localparam int          WORD_BYTES              = 4;

  // PCs below the base wrap to huge offsets, so one unsigned compare covers both ends.
  function automatic logic fetch_addr_bad(input logic [31:0] pc,
                                          input logic [31:0] base,
                                          input logic [31:0] mem_bytes);
    logic [31:0] offset;
    offset = pc - base;
    return (offset >= mem_bytes) || (pc[1:0] != 2'b00);
  endfunction

endpackage

// File: rtl/imem_ctrl_fetch_skid_buf.sv
// One-entry holding register (instruction word + its PC) used when decode stalls
// while a read is already on its way back from memory.
module register_sync #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

module fetch_skid_buf #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic             clear,
  input  logic [WIDTH-1:0] data_in,
  input  logic [31:0]      pc_in,
  output logic             valid,
  output logic [WIDTH-1:0] data,
  output logic [31:0]      pc
);

  logic take;
  logic valid_d;

  // Clear wins over load so a redirect can never leave a stale entry behind.
  assign take    = load && !clear;
  assign valid_d = take;

  register_sync #(.WIDTH(1)) u_valid (
    .clock (clock),
    .reset (reset),
    .en    (load || clear),
    .d     (valid_d),
    .q     (valid)
  );

  register_sync #(.WIDTH(WIDTH)) u_data (
    .clock (clock),
    .reset (reset),
    .en    (take),
    .d     (data_in),
    .q     (data)
  );

  register_sync #(.WIDTH(32)) u_pc (
    .clock (clock),
    .reset (reset),
    .en    (take),
    .d     (pc_in),
    .q     (pc)
  );

endmodule

// File: rtl/imem_ctrl.sv
// Instruction memory sequencer: loads a program into the single-port memory,
// then streams instructions to decode in program order with stall and redirect.
module imem_ctrl
  import imem_ctrl_pkg::*;
#(
  parameter logic [31:0] PC_BASE_ADDR    = DEFAULT_PC_BASE_ADDR,
  parameter int          MEM_DEPTH_WORDS = DEFAULT_MEM_DEPTH_WORDS
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        ld_valid,
  input  logic [31:0] ld_data,
  output logic        ld_ready,
  input  logic        ld_done,
  output logic [31:0] ld_count,
  input  logic        fetch_stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic        instr_valid,
  output logic [31:0] pc,
  output logic        err,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_data_in,
  output logic        mem_rw,
  output logic        mem_en,
  input  logic [31:0] mem_data_out
);

  localparam int          PTR_W     = $clog2(MEM_DEPTH_WORDS + 1);
  localparam logic [31:0] MEM_BYTES = 32'(MEM_DEPTH_WORDS * WORD_BYTES);

  state_t             state;
  state_t             next_state;
  logic [PTR_W-1:0]   wr_ptr;
  logic               inflight;
  logic [31:0]        inflight_pc;
  logic [31:0]        fetch_offset;

  logic               skid_valid;
  logic [31:0]        skid_data;
  logic [31:0]        skid_pc;
  logic               skid_load;
  logic               skid_clear;

  logic               accept;
  logic               issue;
  logic               range_fault;
  logic               redirect_take;
  logic               consume;
  logic               out_from_skid;
  logic               out_from_mem;
  logic               out_clear;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= ST_LOAD;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state    = state;
    ld_ready      = 1'b0;
    accept        = 1'b0;
    issue         = 1'b0;
    range_fault   = 1'b0;
    redirect_take = 1'b0;
    out_from_skid = 1'b0;
    out_from_mem  = 1'b0;
    out_clear     = 1'b0;
    skid_load     = 1'b0;
    skid_clear    = 1'b0;
    fetch_offset  = pc - PC_BASE_ADDR;
    consume       = instr_valid && !fetch_stall;

    case (state)
      ST_LOAD: begin
        ld_ready = reset && (wr_ptr < PTR_W'(MEM_DEPTH_WORDS));
        accept   = ld_valid && ld_ready;
        if (ld_done) begin
          next_state = ST_TURN;
        end
      end
      ST_TURN: begin
        next_state = ST_FETCH;
      end
      ST_FETCH: begin
        // A returning read with a stalled full output must land in the skid, so hold off.
        if (redirect_valid) begin
          redirect_take = 1'b1;
        end else if (!skid_valid && !(inflight && instr_valid && fetch_stall)) begin
          if (fetch_addr_bad(pc, PC_BASE_ADDR, MEM_BYTES)) begin
            range_fault = 1'b1;
            next_state  = ST_ERROR;
          end else begin
            issue = 1'b1;
          end
        end
      end
      default: begin
        next_state = ST_ERROR;
      end
    endcase

    // Output register refill keeps running in ERROR so held words still drain.
    if (redirect_take) begin
      out_clear  = 1'b1;
      skid_clear = 1'b1;
    end else if (consume || !instr_valid) begin
      if (skid_valid) begin
        out_from_skid = 1'b1;
        skid_clear    = 1'b1;
      end else if (inflight) begin
        out_from_mem = 1'b1;
      end else begin
        out_clear = 1'b1;
      end
    end else if (inflight) begin
      skid_load = 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr      <= '0;
      ld_count    <= '0;
      pc          <= PC_BASE_ADDR;
      inflight    <= 1'b0;
      inflight_pc <= '0;
      err         <= 1'b0;
      mem_addr    <= '0;
      mem_data_in <= '0;
      mem_rw      <= MEM_RW_READ;
      mem_en      <= 1'b0;
      instr       <= '0;
      instr_pc    <= '0;
      instr_valid <= 1'b0;
    end else begin
      case (state)
        ST_LOAD: begin
          if (accept) begin
            mem_en      <= 1'b1;
            mem_rw      <= MEM_RW_WRITE;
            mem_addr    <= 32'(wr_ptr) * 32'(WORD_BYTES);
            mem_data_in <= ld_data;
            wr_ptr      <= wr_ptr + PTR_W'(1);
            ld_count    <= ld_count + 32'd1;
          end else begin
            mem_en <= 1'b0;
          end
        end
        ST_TURN: begin
          mem_en <= 1'b0;
          mem_rw <= MEM_RW_READ;
          pc     <= PC_BASE_ADDR;
        end
        ST_FETCH: begin
          if (redirect_take) begin
            pc       <= redirect_pc;
            mem_en   <= 1'b0;
            inflight <= 1'b0;
          end else if (issue) begin
            mem_en      <= 1'b1;
            mem_rw      <= MEM_RW_READ;
            mem_addr    <= fetch_offset;
            inflight    <= 1'b1;
            inflight_pc <= pc;
            pc          <= pc + 32'(WORD_BYTES);
          end else begin
            mem_en   <= 1'b0;
            inflight <= 1'b0;
            if (range_fault) begin
              err <= 1'b1;
            end
          end
        end
        default: begin
          mem_en   <= 1'b0;
          inflight <= 1'b0;
        end
      endcase

      if (out_from_skid) begin
        instr       <= skid_data;
        instr_pc    <= skid_pc;
        instr_valid <= 1'b1;
      end else if (out_from_mem) begin
        instr       <= mem_data_out;
        instr_pc    <= inflight_pc;
        instr_valid <= 1'b1;
      end else if (out_clear) begin
        instr_valid <= 1'b0;
      end
    end
  end

  fetch_skid_buf #(.WIDTH(32)) u_skid (
    .clock   (clock),
    .reset   (reset),
    .load    (skid_load),
    .clear   (skid_clear),
    .data_in (mem_data_out),
    .pc_in   (inflight_pc),
    .valid   (skid_valid),
    .data    (skid_data),
    .pc      (skid_pc)
  );

endmodule

// File: doc/imem_ctrl.md
Name: imem_ctrl

Overview:
- Sequencing controller for the single-port instruction memory (`mem`) and the fetch stage of the CPU.
- Phase 1 (LOAD): accepts program words over a valid/ready loader interface and writes them to consecutive word addresses from 0.
- Phase 2 (FETCH): reads sequentially from PC with PC-relative addressing (mem address = PC - PC_BASE_ADDR) and presents instructions to decode over a stall-able valid interface with redirect support.
- Replaces ad-hoc populate/fetch loops; it is the only driver of the memory's addr/data_in/rw/en.

Parameters:
- PC_BASE_ADDR, 32'h80020000, PC value mapped to memory byte address 0.
- MEM_DEPTH_WORDS, 1024, number of 32-bit words in instruction memory.

Ports:
- clock  in  1  system clock; all state changes on posedge.
- reset  in  1  asynchronous, active-low reset.
- ld_valid  in  1  loader word valid.
- ld_data  in  32  loader instruction word.
- ld_ready  out  1  controller accepts the word this cycle.
- ld_done  in  1  loader finished; sampled in LOAD only.
- ld_count  out  32  words written since reset.
- fetch_stall  in  1  decode cannot accept instr this cycle.
- redirect_valid  in  1  replace PC (branch/jump).
- redirect_pc  in  32  new PC.
- instr  out  32  fetched instruction.
- instr_pc  out  32  PC of instr.
- instr_valid  out  1  instr/instr_pc valid.
- pc  out  32  next PC to be read.
- err  out  1  sticky address-range error.
- mem_addr  out  32  byte address to mem w_addr_32 (registered).
- mem_data_in  out  32  write data to mem w_data_in_32 (registered).
- mem_rw  out  1  0 = write, 1 = read (registered).
- mem_en  out  1  memory enable (registered).
- mem_data_out  in  32  mem w_data_out_32.

Behaviour:
- Reset (reset low, asynchronous): state = LOAD, wr_ptr = 0, ld_count = 0, pc = PC_BASE_ADDR.
  - instr, instr_pc, instr_valid, skid buffer, inflight, err, mem_addr, mem_data_in, mem_en all 0; mem_rw = 1; ld_ready = 0.
  - Applies at any point mid-operation. Memory contents are not cleared.
- States: LOAD -> TURN -> FETCH; any state -> ERROR; exit only by reset.
- LOAD:
  - ld_ready = (wr_ptr < MEM_DEPTH_WORDS) while reset is high.
  - Accept (ld_valid && ld_ready) at edge t launches mem_en = 1, mem_rw = 0, mem_addr = wr_ptr*4, mem_data_in = ld_data; then wr_ptr++ and ld_count++.
  - Cycles without accept: mem_en = 0.
  - Full memory: ld_ready = 0; further words are back-pressured, never dropped.
  - ld_done asserted in the same cycle as an accept: the word is written, then the block transitions.
  - ld_done: next state TURN.
- TURN:
  - Exactly one cycle, mem_en = 0, mem_rw = 1, pc = PC_BASE_ADDR.
  - Then FETCH.
- FETCH, read timing:
  - Read issued at edge t: mem_en = 1, mem_rw = 1, mem_addr = pc - PC_BASE_ADDR, inflight = 1, pc += 4.
  - Data sampled from mem_data_out at edge t+1.
  - Captured into the instr/instr_pc/instr_valid register if it is empty or consumed this cycle (instr_valid && !fetch_stall); otherwise into the one-entry skid buffer.
- FETCH, issue rule: issue when skid empty AND NOT (inflight && instr_valid && fetch_stall). Otherwise mem_en = 0 and pc holds.
- FETCH, consume: instr_valid && !fetch_stall. Skid contents move to the output register on consume.
  - Order is strictly program order.
  - Best case is one instr per cycle; first instr_valid appears two edges after entering FETCH.
- Redirect (redirect_valid in FETCH, takes priority over issue):
  - pc <= redirect_pc.
  - inflight data is discarded when it returns.
  - instr_valid and skid are cleared at that edge.
  - No issue in the redirect cycle; issue resumes next cycle.
- Range check, before issue: if (pc - PC_BASE_ADDR) >= 4*MEM_DEPTH_WORDS (unsigned 32-bit, so PCs below base wrap to large values and fail), or pc[1:0] != 0:
  - No read is issued.
  - State = ERROR, err = 1, mem_en = 0.
  - instr_valid drops after any output-register/skid contents are consumed.
- ERROR: pc frozen; ld_ready = 0; all inputs ignored.
- pc arithmetic: 32-bit, wraps modulo 2^32 (caught by the range check).

Decomposition:
- Package imem_ctrl_pkg:
  - state encoding (LOAD, TURN, FETCH, ERROR);
  - MEM_RW_WRITE = 0, MEM_RW_READ = 1;
  - default PC_BASE_ADDR;
  - WORD_BYTES = 4.
- One sub-module, fetch_skid_buf: 1-entry data+pc holding register with valid and load/clear controls, built on register_sync.

Test Plan:
- Load 3 words 24020005, 24030007, 00621020 then ld_done -> mem writes at 0x0, 0x4, 0x8 with mem_rw = 0; ld_count = 3; one TURN cycle with mem_en = 0; first fetch mem_addr = 0, instr_pc = 0x80020000, instr = 24020005.
- No stall after load -> instr_valid high on consecutive cycles; instr_pc 0x80020000, 0x80020004, 0x80020008; mem_addr increments by 4 per cycle.
- fetch_stall high for 3 cycles while a read is in flight -> skid captures the next word; issue stops; pc holds; after release, instrs arrive in order with none lost or duplicated.
- redirect_valid with redirect_pc = 0x80020008 while a read is in flight -> in-flight word discarded; next instr_pc = 0x80020008.
- Load MEM_DEPTH_WORDS words with ld_valid held -> ld_ready falls after word 1024; sequential fetch past 0x80020FFC -> err = 1, no read issued; redirect_pc = 0x8001FFFC -> ERROR.
- Assert reset mid-FETCH (during a stall with skid full) -> outputs return to reset values asynchronously; state = LOAD; ld_ready = 1 after release; a reload overwrites memory.
